// File: rtl/mul3_stage_pipe_bf16.sv
// Pipelined BF16 x BF16 multiplier: input capture, unpack, mantissa product, normalize/round/pack.
// Optional MUL3_DEBUG_EN exposes the stage mantissas and the raw product as debug outputs.
module mul3_stage_pipe_bf16 #(
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [2*DW-1:0] input_mul,
    input  logic            input_mul_stb,
    output logic            s_input_mul_ack,
    output logic [DW-1:0]   z,
    output logic            s_output_z_stb
`ifdef MUL3_DEBUG_EN
    ,
    output logic [15:0]     mul_men,
    output logic [7:0]      a_mm,
    output logic [7:0]      b_mm
`endif
);

    logic [15:0]        a_p0, b_p0;
    logic               vld_p0;
    logic               sign_p1, nan_p1, inf_p1, zero_p1, vld_p1;
    logic [7:0]         a_man_p1, b_man_p1, a_exp_p1, b_exp_p1;
    logic               sign_p2, nan_p2, inf_p2, zero_p2, vld_p2;
    logic [15:0]        prod_p2;
    logic signed [9:0]  exp_p2;
    logic [15:0]        z_next;

    logic [7:0] ea, eb;
    logic       a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

    assign ea     = a_p0[14:7];
    assign eb     = b_p0[14:7];
    // A zero exponent covers both true zero and subnormals, which are flushed.
    assign a_zero = (ea == 8'h00);
    assign b_zero = (eb == 8'h00);
    assign a_inf  = (ea == 8'hFF) && (a_p0[6:0] == 7'd0);
    assign b_inf  = (eb == 8'hFF) && (b_p0[6:0] == 7'd0);
    assign a_nan  = (ea == 8'hFF) && (a_p0[6:0] != 7'd0);
    assign b_nan  = (eb == 8'hFF) && (b_p0[6:0] != 7'd0);

    // Product in [2^14, 2^16): normalize by at most one place, round to nearest even,
    // then saturate the exponent to inf or flush to zero.
    function automatic logic [15:0] norm_round_pack(input logic sign,
                                                    input logic signed [9:0] exp_in,
                                                    input logic [15:0] prod);
        logic [6:0]        frac;
        logic              guard, sticky, up;
        logic [7:0]        frac_r;
        logic signed [9:0] e;
        if (prod[15]) begin
            frac   = prod[14:8];
            guard  = prod[7];
            sticky = |prod[6:0];
            e      = exp_in + 10'sd1;
        end else begin
            frac   = prod[13:7];
            guard  = prod[6];
            sticky = |prod[5:0];
            e      = exp_in;
        end
        up     = guard & (sticky | frac[0]);
        frac_r = {1'b0, frac} + {7'd0, up};
        if (frac_r[7])
            e = e + 10'sd1;
        if (e >= 10'sd255)
            return {sign, 8'hFF, 7'h00};
        else if (e <= 10'sd0)
            return {sign, 15'h0000};
        else
            return {sign, e[7:0], frac_r[6:0]};
    endfunction

    always_comb begin
        z_next = 16'h0000;
        if (nan_p2)
            z_next = 16'h7FC0;
        else if (inf_p2)
            z_next = {sign_p2, 8'hFF, 7'h00};
        else if (zero_p2)
            z_next = {sign_p2, 15'h0000};
        else
            z_next = norm_round_pack(sign_p2, exp_p2, prod_p2);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_input_mul_ack <= 1'b0;
            a_p0            <= 16'h0000;
            b_p0            <= 16'h0000;
            vld_p0          <= 1'b0;
            sign_p1         <= 1'b0;
            nan_p1          <= 1'b0;
            inf_p1          <= 1'b0;
            zero_p1         <= 1'b0;
            vld_p1          <= 1'b0;
            a_man_p1        <= 8'h00;
            b_man_p1        <= 8'h00;
            a_exp_p1        <= 8'h00;
            b_exp_p1        <= 8'h00;
            sign_p2         <= 1'b0;
            nan_p2          <= 1'b0;
            inf_p2          <= 1'b0;
            zero_p2         <= 1'b0;
            vld_p2          <= 1'b0;
            prod_p2         <= 16'h0000;
            exp_p2          <= 10'sd0;
            z               <= 16'h0000;
            s_output_z_stb  <= 1'b0;
        end else begin
            // Input capture
            s_input_mul_ack <= 1'b1;
            vld_p0          <= input_mul_stb && s_input_mul_ack;
            if (input_mul_stb && s_input_mul_ack) begin
                a_p0 <= input_mul[2*DW-1:DW];
                b_p0 <= input_mul[DW-1:0];
            end
            // Stage 1: unpack and classify
            vld_p1   <= vld_p0;
            sign_p1  <= a_p0[15] ^ b_p0[15];
            nan_p1   <= a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero);
            inf_p1   <= a_inf | b_inf;
            zero_p1  <= a_zero | b_zero;
            a_man_p1 <= {~a_zero, a_p0[6:0]};
            b_man_p1 <= {~b_zero, b_p0[6:0]};
            a_exp_p1 <= ea;
            b_exp_p1 <= eb;
            // Stage 2: mantissa product and biased exponent sum
            vld_p2  <= vld_p1;
            sign_p2 <= sign_p1;
            nan_p2  <= nan_p1;
            inf_p2  <= inf_p1;
            zero_p2 <= zero_p1;
            prod_p2 <= {8'd0, a_man_p1} * {8'd0, b_man_p1};
            exp_p2  <= $signed({2'b00, a_exp_p1}) + $signed({2'b00, b_exp_p1}) - 10'sd127;
            // Stage 3: normalize, round, pack
            s_output_z_stb <= vld_p2;
            if (vld_p2)
                z <= z_next;
        end
    end

`ifdef MUL3_DEBUG_EN
    assign mul_men = prod_p2;
    assign a_mm    = a_man_p1;
    assign b_mm    = b_man_p1;
`endif

endmodule

// File: tb/tb_mul3_stage_pipe_bf16.sv
// Randomized and directed bench for the BF16 pipelined multiplier, checked against
// an integer-arithmetic reference model of BF16 multiply with round-to-nearest-even.
module tb_mul3_stage_pipe_bf16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] input_mul = 32'h0;
    logic        input_mul_stb = 1'b0;
    logic        s_input_mul_ack;
    logic [15:0] z;
    logic        s_output_z_stb;
`ifdef MUL3_DEBUG_EN
    logic [15:0] mul_men;
    logic [7:0]  a_mm, b_mm;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    mul3_stage_pipe_bf16 #(.DW(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .input_mul      (input_mul),
        .input_mul_stb  (input_mul_stb),
        .s_input_mul_ack(s_input_mul_ack),
        .z              (z),
        .s_output_z_stb (s_output_z_stb)
`ifdef MUL3_DEBUG_EN
        ,
        .mul_men        (mul_men),
        .a_mm           (a_mm),
        .b_mm           (b_mm)
`endif
    );

    // {a, b, expected product}
    localparam logic [15:0] ROUND_TBL [2][3] = '{
        '{16'h3F81, 16'h3F81, 16'h3F82},
        '{16'h3FC0, 16'h3F81, 16'h3FC2}
    };
    localparam logic [15:0] SPECIAL_TBL [5][3] = '{
        '{16'h7F80, 16'h0000, 16'h7FC0},
        '{16'hFF80, 16'h4000, 16'hFF80},
        '{16'h7F00, 16'h4000, 16'h7F80},
        '{16'h0080, 16'h0080, 16'h0000},
        '{16'h8000, 16'h3F80, 16'h8000}
    };

    // Value of a normal operand is (128+f) * 2^(e-134); multiply exactly as integers,
    // then divide down to 8 significant bits with round-half-to-even.
    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, fa, fb, p, k, q, rem, half, e;
        logic s;
        ea = int'(a[14:7]); eb = int'(b[14:7]);
        fa = int'(a[6:0]);  fb = int'(b[6:0]);
        s  = a[15] ^ b[15];
        if ((ea == 255 && fa != 0) || (eb == 255 && fb != 0) ||
            (ea == 255 && eb == 0) || (eb == 255 && ea == 0))
            return 16'h7FC0;
        if (ea == 255 || eb == 255)
            return {s, 15'h7F80};
        if (ea == 0 || eb == 0)
            return {s, 15'h0000};
        p = (128 + fa) * (128 + fb);
        k = 0;
        while ((p >> k) >= 256) k++;
        q    = p >> k;
        rem  = p - (q << k);
        half = 1 << (k - 1);
        if (rem > half || (rem == half && (q % 2) == 1)) q++;
        if (q == 256) begin
            q = 128;
            k++;
        end
        e = ea + eb - 127 + (k - 7);
        if (e >= 255) return {s, 15'h7F80};
        if (e <= 0)   return {s, 15'h0000};
        return {s, e[7:0], q[6:0]};
    endfunction

    // Drives one pair for one cycle and reports how many edges after acceptance the strobe came.
    task automatic send_pair(input logic [15:0] a, input logic [15:0] b,
                             output logic [15:0] zo, output int lat);
        @(negedge clk);
        input_mul     = {a, b};
        input_mul_stb = 1'b1;
        @(negedge clk);
        input_mul_stb = 1'b0;
        lat = -1;
        zo  = 16'h0000;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (s_output_z_stb) begin
                lat = k;
                zo  = z;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if (z !== 16'h0000) begin miscompares++; $display("FAIL reset_z: got %h want 0000", z); end
        vectors++;
        if (s_output_z_stb !== 1'b0) begin miscompares++; $display("FAIL reset_stb: got %b want 0", s_output_z_stb); end
        vectors++;
        if (s_input_mul_ack !== 1'b0) begin miscompares++; $display("FAIL reset_ack: got %b want 0", s_input_mul_ack); end
        rst = 1'b1;
        #1;
        vectors++;
        if (s_input_mul_ack !== 1'b0) begin miscompares++; $display("FAIL ack_before_edge: got %b want 0", s_input_mul_ack); end
        @(negedge clk);
        vectors++;
        if (s_input_mul_ack !== 1'b1) begin miscompares++; $display("FAIL ack_after_release: got %b want 1", s_input_mul_ack); end
    endtask

    task automatic test_basic();
        logic [15:0] zo;
        int lat;
        send_pair(16'h3FC0, 16'h4000, zo, lat);
        vectors++;
        if (lat !== 3) begin miscompares++; $display("FAIL basic_latency: got %0d want 3", lat); end
        vectors++;
        if (zo !== 16'h4040) begin miscompares++; $display("FAIL basic_z: got %h want 4040", zo); end
        @(negedge clk);
        vectors++;
        if (s_output_z_stb !== 1'b0) begin miscompares++; $display("FAIL basic_stb_width: got %b want 0", s_output_z_stb); end
        vectors++;
        if (z !== 16'h4040) begin miscompares++; $display("FAIL basic_z_hold: got %h want 4040", z); end
    endtask

    task automatic test_rounding();
        logic [15:0] zo;
        int lat;
        for (int i = 0; i < 2; i++) begin
            send_pair(ROUND_TBL[i][0], ROUND_TBL[i][1], zo, lat);
            vectors++;
            if (zo !== ROUND_TBL[i][2] || lat !== 3) begin
                miscompares++;
                $display("FAIL rounding[%0d] %h*%h: got %h lat %0d want %h lat 3",
                         i, ROUND_TBL[i][0], ROUND_TBL[i][1], zo, lat, ROUND_TBL[i][2]);
            end
        end
    endtask

    task automatic test_specials();
        logic [15:0] zo;
        int lat;
        for (int i = 0; i < 5; i++) begin
            send_pair(SPECIAL_TBL[i][0], SPECIAL_TBL[i][1], zo, lat);
            vectors++;
            if (zo !== SPECIAL_TBL[i][2] || lat !== 3) begin
                miscompares++;
                $display("FAIL special[%0d] %h*%h: got %h lat %0d want %h lat 3",
                         i, SPECIAL_TBL[i][0], SPECIAL_TBL[i][1], zo, lat, SPECIAL_TBL[i][2]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] av [32];
        logic [15:0] bv [32];
        logic [15:0] got [$];
        int          at [$];
        for (int i = 0; i < 32; i++) begin
            if (i % 2 == 0) begin
                av[i] = 16'($urandom);
                bv[i] = 16'($urandom);
            end else begin
                av[i] = {1'($urandom), 8'($urandom_range(100, 154)), 7'($urandom)};
                bv[i] = {1'($urandom), 8'($urandom_range(100, 154)), 7'($urandom)};
            end
        end
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            if (s_output_z_stb) begin
                got.push_back(z);
                at.push_back(cyc);
            end
            if (cyc < 32) begin
                input_mul     = {av[cyc], bv[cyc]};
                input_mul_stb = 1'b1;
            end else begin
                input_mul_stb = 1'b0;
            end
        end
        vectors++;
        if (got.size() !== 32) begin miscompares++; $display("FAIL b2b_count: got %0d want 32", got.size()); end
        for (int i = 0; i < 32 && i < got.size(); i++) begin
            vectors++;
            if (got[i] !== ref_mul(av[i], bv[i]) || at[i] !== i + 4) begin
                miscompares++;
                $display("FAIL b2b[%0d] %h*%h: got %h at cycle %0d want %h at cycle %0d",
                         i, av[i], bv[i], got[i], at[i], ref_mul(av[i], bv[i]), i + 4);
            end
        end
    endtask

    task automatic test_reset_in_flight();
        logic [15:0] zo;
        int lat;
        int strobes;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            input_mul     = {16'h3FC0 + 16'(i), 16'h4000};
            input_mul_stb = 1'b1;
        end
        @(negedge clk);
        input_mul_stb = 1'b0;
        #1 rst = 1'b0;
        #1;
        vectors++;
        if (z !== 16'h0000 || s_output_z_stb !== 1'b0) begin
            miscompares++;
            $display("FAIL flight_async_clear: got z=%h stb=%b want z=0000 stb=0", z, s_output_z_stb);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (s_input_mul_ack !== 1'b0) begin miscompares++; $display("FAIL flight_ack_in_reset: got %b want 0", s_input_mul_ack); end
        rst = 1'b1;
        strobes = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (s_output_z_stb) strobes++;
        end
        vectors++;
        if (strobes !== 0) begin miscompares++; $display("FAIL flight_discard: got %0d strobes want 0", strobes); end
        send_pair(16'h4040, 16'hC000, zo, lat);
        vectors++;
        if (zo !== ref_mul(16'h4040, 16'hC000) || lat !== 3) begin
            miscompares++;
            $display("FAIL flight_after_release: got %h lat %0d want %h lat 3", zo, lat, ref_mul(16'h4040, 16'hC000));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_specials();
        test_back_to_back();
        test_reset_in_flight();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
